result_bus_arbiter: RTL and testbench

//  Common result bus (CDB) stage fed by all execution-unit wrappers (add/sub, logic, mul, ...).

---
 rtl/result_bus_arbiter.sv | 114 +++++++++++
 tb/tb_result_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_bus_arbiter.sv
// Common result bus stage: round-robin arbitration of execution-unit result
// channels, one registered winner broadcast per cycle to the reservation
// stations and GPR/CR/XER writeback.

package result_bus_pkg;

    // CR0 field plus the XER bits a result can update
    typedef struct packed {
        logic [3:0] cr0;   // lt, gt, eq, so
        logic       so;
        logic       ov;
        logic       ca;
    } cond_exception_t;

endpackage

module result_bus_arbiter
    import result_bus_pkg::*;
#(
    parameter int UNITS       = 4,
    parameter int RS_ID_WIDTH = 5,
    localparam int PTR_W      = (UNITS > 1) ? $clog2(UNITS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [UNITS-1:0]                      unit_valid,
    output logic [UNITS-1:0]                      unit_ready,
    input  logic [UNITS-1:0][RS_ID_WIDTH-1:0]     unit_rs_id,
    input  logic [UNITS-1:0][4:0]                 unit_reg_addr,
    input  logic [UNITS-1:0][31:0]                unit_result,
    input  cond_exception_t [UNITS-1:0]           unit_cr0_xer,
    input  logic                                  hold,
    output logic                                  bus_valid,
    output logic [RS_ID_WIDTH-1:0]                bus_rs_id,
    output logic [4:0]                            bus_reg_addr,
    output logic [31:0]                           bus_value,
    output cond_exception_t                       bus_cr0_xer,
    output logic [PTR_W-1:0]                      bus_unit
);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_next;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;
    logic             found;
    int unsigned      scan_idx;

    // Scan valid units starting at rr_ptr; first valid one wins unless held or in reset
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = 0; k < UNITS; k++) begin
            scan_idx = (int'(rr_ptr) + k) % UNITS;
            if (!found && unit_valid[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx[PTR_W-1:0];
            end
        end
        grant_any  = found && !hold && rst;
        unit_ready = '0;
        if (grant_any) begin
            unit_ready[grant_idx] = 1'b1;
        end
    end

    // Pointer moves just past the winner, wrapping at the last unit
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant_any) begin
            if (grant_idx == PTR_W'(UNITS - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_idx + 1'b1;
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // Valid pulses for exactly one cycle per accepted result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_valid <= 1'b0;
        end else begin
            bus_valid <= grant_any;
        end
    end

    // Winner payload is captured on a grant; otherwise the last value is kept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_rs_id    <= '0;
            bus_reg_addr <= '0;
            bus_value    <= '0;
            bus_cr0_xer  <= '0;
            bus_unit     <= '0;
        end else if (grant_any) begin
            bus_rs_id    <= unit_rs_id[grant_idx];
            bus_reg_addr <= unit_reg_addr[grant_idx];
            bus_value    <= unit_result[grant_idx];
            bus_cr0_xer  <= unit_cr0_xer[grant_idx];
            bus_unit     <= grant_idx;
        end
    end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed and random checks for result_bus_arbiter (UNITS=4, RS_ID_WIDTH=5).

module tb_result_bus_arbiter;
    import result_bus_pkg::*;

    localparam int UNITS = 4;
    localparam int RSW   = 5;

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic [UNITS-1:0]              unit_valid;
    logic [UNITS-1:0]              unit_ready;
    logic [UNITS-1:0][RSW-1:0]     unit_rs_id;
    logic [UNITS-1:0][4:0]         unit_reg_addr;
    logic [UNITS-1:0][31:0]        unit_result;
    cond_exception_t [UNITS-1:0]   unit_cr0_xer;
    logic                          hold;
    logic                          bus_valid;
    logic [RSW-1:0]                bus_rs_id;
    logic [4:0]                    bus_reg_addr;
    logic [31:0]                   bus_value;
    cond_exception_t               bus_cr0_xer;
    logic [1:0]                    bus_unit;

    int checks   = 0;
    int failures = 0;

    result_bus_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RSW)) dut (
        .clk          (clk),
        .rst          (rst),
        .unit_valid   (unit_valid),
        .unit_ready   (unit_ready),
        .unit_rs_id   (unit_rs_id),
        .unit_reg_addr(unit_reg_addr),
        .unit_result  (unit_result),
        .unit_cr0_xer (unit_cr0_xer),
        .hold         (hold),
        .bus_valid    (bus_valid),
        .bus_rs_id    (bus_rs_id),
        .bus_reg_addr (bus_reg_addr),
        .bus_value    (bus_value),
        .bus_cr0_xer  (bus_cr0_xer),
        .bus_unit     (bus_unit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pay_result(int u, int s);
        return {u[7:0], s[23:0]};
    endfunction
    function automatic logic [RSW-1:0] pay_rs(int u, int s);
        return RSW'((u * 7 + s) % 32);
    endfunction
    function automatic logic [4:0] pay_reg(int u, int s);
        return 5'((s * 3 + u) % 32);
    endfunction
    function automatic cond_exception_t pay_cr(int u, int s);
        return cond_exception_t'(7'((s + u * 5) % 128));
    endfunction

    task automatic set_payload(int u, int s);
        unit_rs_id[u]    = pay_rs(u, s);
        unit_reg_addr[u] = pay_reg(u, s);
        unit_result[u]   = pay_result(u, s);
        unit_cr0_xer[u]  = pay_cr(u, s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(string tag, int u, int s);
        check({tag, "_valid"}, 64'(bus_valid), 64'(1));
        check({tag, "_unit"},  64'(bus_unit), 64'(u));
        check({tag, "_value"}, 64'(bus_value), 64'(pay_result(u, s)));
        check({tag, "_rs"},    64'(bus_rs_id), 64'(pay_rs(u, s)));
        check({tag, "_reg"},   64'(bus_reg_addr), 64'(pay_reg(u, s)));
        check({tag, "_cr"},    64'(bus_cr0_xer), 64'(pay_cr(u, s)));
    endtask

    int seq [UNITS];
    int pseq[UNITS];
    int nseq[UNITS];
    int waitc[UNITS];
    logic [UNITS-1:0] presenting;
    int mptr;
    int g;
    int j;
    bit found;
    logic [UNITS-1:0] exp_ready;
    bit exp_bv;
    int exp_u;
    int exp_s;

    initial begin
        unit_valid    = '1;
        hold          = 1'b0;
        unit_rs_id    = '0;
        unit_reg_addr = '0;
        unit_result   = '0;
        unit_cr0_xer  = '0;

        // reset state (units valid during reset must not be granted)
        #12;
        check("rst_bus_valid", 64'(bus_valid), 64'(0));
        check("rst_bus_value", 64'(bus_value), 64'(0));
        check("rst_bus_rs",    64'(bus_rs_id), 64'(0));
        check("rst_bus_reg",   64'(bus_reg_addr), 64'(0));
        check("rst_bus_cr",    64'(bus_cr0_xer), 64'(0));
        check("rst_bus_unit",  64'(bus_unit), 64'(0));
        check("rst_ready",     64'(unit_ready), 64'(0));
        unit_valid = '0;
        #10 rst = 1'b1;
        tick();

        // test 1: single result from unit 0
        unit_valid       = 4'b0001;
        unit_rs_id[0]    = 5'd3;
        unit_reg_addr[0] = 5'd7;
        unit_result[0]   = 32'h0000_0005;
        unit_cr0_xer[0]  = cond_exception_t'(7'h25);
        #1;
        check("t1_ready", 64'(unit_ready), 64'(4'b0001));
        tick();
        unit_valid = '0;
        check("t1_valid", 64'(bus_valid), 64'(1));
        check("t1_rs",    64'(bus_rs_id), 64'(3));
        check("t1_reg",   64'(bus_reg_addr), 64'(7));
        check("t1_value", 64'(bus_value), 64'(5));
        check("t1_cr",    64'(bus_cr0_xer), 64'(7'h25));
        check("t1_unit",  64'(bus_unit), 64'(0));
        #1;
        check("t1_ready_off", 64'(unit_ready), 64'(0));
        tick();
        check("t1_pulse_end", 64'(bus_valid), 64'(0));
        check("t1_value_kept", 64'(bus_value), 64'(5));

        // test 2: all valid from reset rotates 0,1,2,3,...
        rst = 1'b0;
        #2 rst = 1'b1;
        for (int u = 0; u < UNITS; u++) begin
            seq[u] = 0;
            set_payload(u, 0);
        end
        unit_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t2_ready", 64'(unit_ready), 64'(1 << (k % UNITS)));
            tick();
            check_bus("t2", k % UNITS, seq[k % UNITS]);
            seq[k % UNITS]++;
            set_payload(k % UNITS, seq[k % UNITS]);
        end
        unit_valid = '0;
        tick();
        check("t2_idle", 64'(bus_valid), 64'(0));

        // test 3: bring rr_ptr to 2 via unit 1, then units 1 and 3 valid
        set_payload(1, 20);
        unit_valid = 4'b0010;
        tick();
        check_bus("t3_pre", 1, 20);
        set_payload(1, 21);
        set_payload(3, 30);
        unit_valid = 4'b1010;
        #1;
        check("t3_ready_a", 64'(unit_ready), 64'(4'b1000));
        tick();
        check_bus("t3_a", 3, 30);
        unit_valid = 4'b0010;
        #1;
        check("t3_ready_b", 64'(unit_ready), 64'(4'b0010));
        tick();
        check_bus("t3_b", 1, 21);

        // test 4: hold with unit 2 valid, in-flight result still broadcast
        set_payload(2, 40);
        unit_valid = 4'b0100;
        hold       = 1'b1;
        #1;
        check("t4_inflight_valid", 64'(bus_valid), 64'(1));
        check("t4_inflight_unit",  64'(bus_unit), 64'(1));
        for (int k = 0; k < 3; k++) begin
            check("t4_ready_held", 64'(unit_ready), 64'(0));
            tick();
            check("t4_bus_idle", 64'(bus_valid), 64'(0));
        end
        hold = 1'b0;
        #1;
        check("t4_ready_release", 64'(unit_ready), 64'(4'b0100));
        tick();
        check_bus("t4", 2, 40);

        // test 5: asynchronous reset while bus_valid=1
        unit_valid = '1;
        for (int u = 0; u < UNITS; u++) set_payload(u, 50 + u);
        #2 rst = 1'b0;
        #1;
        check("t5_valid_drop", 64'(bus_valid), 64'(0));
        check("t5_value_clr",  64'(bus_value), 64'(0));
        check("t5_ready_rst",  64'(unit_ready), 64'(0));
        #3 rst = 1'b1;
        #1;
        check("t5_ready_after", 64'(unit_ready), 64'(4'b0001));
        tick();
        check_bus("t5", 0, 50);
        unit_valid = '0;
        tick();
        check("t5_idle", 64'(bus_valid), 64'(0));

        // test 6: random traffic against a round-robin reference and per-unit sequences
        mptr       = 1;
        presenting = '0;
        exp_bv     = 1'b0;
        for (int u = 0; u < UNITS; u++) begin
            nseq[u]  = 100;
            waitc[u] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            hold = ($urandom_range(0, 3) == 0);
            for (int u = 0; u < UNITS; u++) begin
                if (!presenting[u] && ($urandom_range(0, 1) == 1)) begin
                    presenting[u] = 1'b1;
                    pseq[u]       = nseq[u];
                    nseq[u]++;
                    set_payload(u, pseq[u]);
                end
            end
            unit_valid = presenting;
            #1;
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < UNITS; k++) begin
                j = (mptr + k) % UNITS;
                if (!found && presenting[j]) begin
                    found = 1'b1;
                    g     = j;
                end
            end
            exp_ready = (found && !hold) ? 4'(1 << g) : 4'b0000;
            check("rnd_ready", 64'(unit_ready), 64'(exp_ready));
            for (int u = 0; u < UNITS; u++) begin
                if (presenting[u] && !hold && !(found && g == u)) begin
                    waitc[u]++;
                    check("rnd_wait_bound", 64'(waitc[u] < UNITS), 64'(1));
                end
            end
            if (found && !hold) begin
                exp_bv        = 1'b1;
                exp_u         = g;
                exp_s         = pseq[g];
                presenting[g] = 1'b0;
                waitc[g]      = 0;
                mptr          = (g + 1) % UNITS;
            end else begin
                exp_bv = 1'b0;
            end
            tick();
            if (exp_bv) begin
                check_bus("rnd", exp_u, exp_s);
            end else begin
                check("rnd_idle", 64'(bus_valid), 64'(0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
